// File: rtl/cam_pkg.sv
// Shared constants and helpers for the parameterised CAM.
// Holds the default entry width and depth plus the index-width function.
package cam_pkg;

    localparam int CAM_DATA_W_DEF = 8;
    localparam int CAM_DEPTH_DEF  = 8;

    // Index width for a given depth; never narrower than one bit.
    function automatic int cam_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/param_cam_if.sv
// Request/result bundle between a CAM client (master) and the CAM (slave).
// Optional feature macro: CAM_MASK_EN adds the srch_mask don't-care input.
interface param_cam_if
    import cam_pkg::*;
#(
    parameter int DATA_W = CAM_DATA_W_DEF,
    parameter int DEPTH  = CAM_DEPTH_DEF,
    parameter int AW     = cam_idx_w(DEPTH)
) ();

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              inv_en;
    logic              clr_all;
    logic              srch_req;
    logic [DATA_W-1:0] srch_key;
`ifdef CAM_MASK_EN
    logic [DATA_W-1:0] srch_mask;
`endif
    logic              srch_done;
    logic [DEPTH-1:0]  match_vec;
    logic              hit;
    logic [AW-1:0]     hit_idx;
    logic [AW:0]       used_cnt;
    logic              full;

    modport master (
        output wr_en, wr_addr, wr_data, inv_en, clr_all, srch_req, srch_key,
`ifdef CAM_MASK_EN
        output srch_mask,
`endif
        input  srch_done, match_vec, hit, hit_idx, used_cnt, full
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, inv_en, clr_all, srch_req, srch_key,
`ifdef CAM_MASK_EN
        input  srch_mask,
`endif
        output srch_done, match_vec, hit, hit_idx, used_cnt, full
    );

endinterface

// File: rtl/cam_prio_enc.sv
// Lowest-index-first priority encoder turning a match vector into hit/index.
// Purely combinational; index is 0 when nothing matches.
module cam_prio_enc
    import cam_pkg::*;
#(
    parameter int DEPTH = CAM_DEPTH_DEF,
    parameter int AW    = cam_idx_w(DEPTH)
) (
    input  logic [DEPTH-1:0] match_vec_i,
    output logic             hit_o,
    output logic [AW-1:0]    hit_idx_o
);

    // Scan from the top down so the lowest set bit is the last one assigned.
    always_comb begin
        // NOTE: every output gets a default before any conditional assignment,
        // otherwise synthesis infers a latch to hold the old value.
        hit_o     = |match_vec_i;
        hit_idx_o = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match_vec_i[i]) hit_idx_o = AW'(i);
        end
    end

endmodule

// File: rtl/param_cam.sv
// Parameterised content-addressable memory with valid bits and occupancy count.
// Searches take one cycle and see state from before the sampling edge.
// Optional feature macro: CAM_MASK_EN enables per-bit don't-care masking.
module param_cam
    import cam_pkg::*;
#(
    parameter int DATA_W = CAM_DATA_W_DEF,
    parameter int DEPTH  = CAM_DEPTH_DEF,
    parameter int AW     = cam_idx_w(DEPTH)
) (
    input logic        clk,
    input logic        rst,
    param_cam_if.slave bus
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW + 1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [AW:0]       used_cnt_q, used_cnt_d;
    logic              mem_we;
    logic              addr_ok;

    logic [DEPTH-1:0]  match_d, match_vec_q;
    logic              hit_d, hit_q;
    logic [AW-1:0]     hit_idx_d, hit_idx_q;
    logic              srch_done_q;

    // Addresses beyond the last entry are silently ignored.
    assign addr_ok = ({1'b0, bus.wr_addr} < DEPTH_C);

    // Next valid vector and count; clear beats invalidate beats write.
    always_comb begin
        valid_d    = valid_q;
        used_cnt_d = used_cnt_q;
        mem_we     = 1'b0;
        if (bus.clr_all) begin
            valid_d    = '0;
            used_cnt_d = '0;
        end else if (bus.inv_en) begin
            if (addr_ok && valid_q[bus.wr_addr]) begin
                valid_d[bus.wr_addr] = 1'b0;
                used_cnt_d           = used_cnt_q - ONE_C;
            end
        end else if (bus.wr_en && addr_ok) begin
            mem_we = 1'b1;
            if (!valid_q[bus.wr_addr]) begin
                valid_d[bus.wr_addr] = 1'b1;
                used_cnt_d           = used_cnt_q + ONE_C;
            end
        end
    end

    // Compare the key against every valid entry using pre-edge storage.
    always_comb begin
        match_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef CAM_MASK_EN
            match_d[i] = valid_q[i] &&
                         (((mem_q[i] ^ bus.srch_key) & ~bus.srch_mask) == '0);
`else
            match_d[i] = valid_q[i] && (mem_q[i] == bus.srch_key);
`endif
        end
    end

    cam_prio_enc #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prio_enc (
        .match_vec_i (match_d),
        .hit_o       (hit_d),
        .hit_idx_o   (hit_idx_d)
    );

    // Entry storage: data only, written when the write wins arbitration.
    // NOTE: the data array has no reset; the valid bits alone say whether an
    // entry means anything, and leaving it unreset keeps it as plain flops/RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[bus.wr_addr] <= bus.wr_data;
    end

    // Control state and registered search results; results hold between searches.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values,
        // which is exactly what makes a same-cycle write invisible to a search.
        if (rst) begin
            valid_q     <= '0;
            used_cnt_q  <= '0;
            srch_done_q <= 1'b0;
            match_vec_q <= '0;
            hit_q       <= 1'b0;
            hit_idx_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            used_cnt_q  <= used_cnt_d;
            srch_done_q <= bus.srch_req;
            if (bus.srch_req) begin
                match_vec_q <= match_d;
                hit_q       <= hit_d;
                hit_idx_q   <= hit_idx_d;
            end
        end
    end

    assign bus.srch_done = srch_done_q;
    assign bus.match_vec = match_vec_q;
    assign bus.hit       = hit_q;
    assign bus.hit_idx   = hit_idx_q;
    assign bus.used_cnt  = used_cnt_q;
    assign bus.full      = (used_cnt_q == DEPTH_C);

endmodule

// File: tb/tb_param_cam.sv
// Directed, table-driven bench for param_cam (DATA_W=8, DEPTH=8).
// Build with CAM_MASK_EN defined to also exercise the don't-care mask.
module tb_param_cam;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    param_cam_if #(.DATA_W(8), .DEPTH(8), .AW(3)) bus ();

    param_cam #(.DATA_W(8), .DEPTH(8), .AW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      name;
        logic       wr, inv, clr, srch;
        logic [2:0] addr;
        logic [7:0] data, key;
        logic       e_done;
        logic [7:0] e_mv;
        logic       e_hit;
        logic [2:0] e_idx;
        logic [3:0] e_cnt;
        logic       e_full;
    } vec_t;

    vec_t vq[$];

    function automatic void add(string n, logic wr, logic inv, logic clr, logic srch,
                                logic [2:0] a, logic [7:0] d, logic [7:0] k,
                                logic ed, logic [7:0] emv, logic eh, logic [2:0] ei,
                                logic [3:0] ec, logic ef);
        vec_t v;
        v.name = n; v.wr = wr; v.inv = inv; v.clr = clr; v.srch = srch;
        v.addr = a; v.data = d; v.key = k;
        v.e_done = ed; v.e_mv = emv; v.e_hit = eh; v.e_idx = ei;
        v.e_cnt = ec; v.e_full = ef;
        vq.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(string n, logic ed, logic [7:0] emv, logic eh,
                              logic [2:0] ei, logic [3:0] ec, logic ef);
        check({n, ".srch_done"}, 32'(bus.srch_done), 32'(ed));
        check({n, ".match_vec"}, 32'(bus.match_vec), 32'(emv));
        check({n, ".hit"},       32'(bus.hit),       32'(eh));
        check({n, ".hit_idx"},   32'(bus.hit_idx),   32'(ei));
        check({n, ".used_cnt"},  32'(bus.used_cnt),  32'(ec));
        check({n, ".full"},      32'(bus.full),      32'(ef));
    endtask

    task automatic drive(logic wr, logic inv, logic clr, logic srch,
                         logic [2:0] a, logic [7:0] d, logic [7:0] k);
        bus.wr_en    = wr;
        bus.inv_en   = inv;
        bus.clr_all  = clr;
        bus.srch_req = srch;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        bus.srch_key = k;
    endtask

    initial begin
        drive(0, 0, 0, 0, 3'd0, 8'h00, 8'h00);
`ifdef CAM_MASK_EN
        bus.srch_mask = 8'h00;
`endif

        // Expected values after each edge:   done mv    hit idx cnt full
        add("wr3_a5",    1,0,0,0, 3'd3, 8'hA5, 8'h00,  0, 8'h00, 0, 3'd0, 4'd1, 0);
        add("srch_a5",   0,0,0,1, 3'd0, 8'h00, 8'hA5,  1, 8'h08, 1, 3'd3, 4'd1, 0);
        add("inv3",      0,1,0,0, 3'd3, 8'h00, 8'h00,  0, 8'h08, 1, 3'd3, 4'd0, 0);
        add("inv3_again",0,1,0,0, 3'd3, 8'h00, 8'h00,  0, 8'h08, 1, 3'd3, 4'd0, 0);
        add("wr2_11",    1,0,0,0, 3'd2, 8'h11, 8'h00,  0, 8'h08, 1, 3'd3, 4'd1, 0);
        add("wr6_11",    1,0,0,0, 3'd6, 8'h11, 8'h00,  0, 8'h08, 1, 3'd3, 4'd2, 0);
        add("srch_11a",  0,0,0,1, 3'd0, 8'h00, 8'h11,  1, 8'h44, 1, 3'd2, 4'd2, 0);
        add("inv2",      0,1,0,0, 3'd2, 8'h00, 8'h00,  0, 8'h44, 1, 3'd2, 4'd1, 0);
        add("srch_11b",  0,0,0,1, 3'd0, 8'h00, 8'h11,  1, 8'h40, 1, 3'd6, 4'd1, 0);
        add("wr_srch_7e",1,0,0,1, 3'd0, 8'h7E, 8'h7E,  1, 8'h00, 0, 3'd0, 4'd2, 0);
        add("srch_7e",   0,0,0,1, 3'd0, 8'h00, 8'h7E,  1, 8'h01, 1, 3'd0, 4'd2, 0);
        add("inv_wr6",   1,1,0,0, 3'd6, 8'h55, 8'h00,  0, 8'h01, 1, 3'd0, 4'd1, 0);
        add("srch_55",   0,0,0,1, 3'd0, 8'h00, 8'h55,  1, 8'h00, 0, 3'd0, 4'd1, 0);
        for (int i = 0; i < 8; i++) begin
            add($sformatf("fill%0d", i), 1,0,0,0, 3'(i), 8'h30 + 8'(i), 8'h00,
                0, 8'h00, 0, 3'd0, (i == 0) ? 4'd1 : 4'(i + 1), (i == 7));
        end
        add("ovr5_99",   1,0,0,0, 3'd5, 8'h99, 8'h00,  0, 8'h00, 0, 3'd0, 4'd8, 1);
        add("srch_35",   0,0,0,1, 3'd0, 8'h00, 8'h35,  1, 8'h00, 0, 3'd0, 4'd8, 1);
        add("srch_99",   0,0,0,1, 3'd0, 8'h00, 8'h99,  1, 8'h20, 1, 3'd5, 4'd8, 1);
        add("clr_wr4",   1,0,1,0, 3'd4, 8'hC4, 8'h00,  0, 8'h20, 1, 3'd5, 4'd0, 0);
        add("srch_c4",   0,0,0,1, 3'd0, 8'h00, 8'hC4,  1, 8'h00, 0, 3'd0, 4'd0, 0);
        add("srch_30",   0,0,0,1, 3'd0, 8'h00, 8'h30,  1, 8'h00, 0, 3'd0, 4'd0, 0);

        // Reset state, both during and right after reset.
        repeat (2) @(posedge clk);
        #1 check_outs("in_reset", 0, 8'h00, 0, 3'd0, 4'd0, 0);
        @(negedge clk) rst = 1'b0;
        #1 check_outs("post_reset", 0, 8'h00, 0, 3'd0, 4'd0, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].wr, vq[i].inv, vq[i].clr, vq[i].srch,
                  vq[i].addr, vq[i].data, vq[i].key);
            @(posedge clk);
            #1 check_outs(vq[i].name, vq[i].e_done, vq[i].e_mv, vq[i].e_hit,
                          vq[i].e_idx, vq[i].e_cnt, vq[i].e_full);
        end

        // Reset asserted mid-cycle while a search is pending: it must be dropped.
        @(negedge clk) drive(1, 0, 0, 0, 3'd1, 8'h42, 8'h00);
        @(negedge clk) drive(0, 0, 0, 1, 3'd0, 8'h00, 8'h42);
        @(posedge clk);
        #1 check_outs("pre_rst_hit", 1, 8'h02, 1, 3'd1, 4'd1, 0);
        @(negedge clk) drive(0, 0, 0, 1, 3'd0, 8'h00, 8'h42);
        #2 rst = 1'b1;
        #1 check_outs("async_rst", 0, 8'h00, 0, 3'd0, 4'd0, 0);
        drive(0, 0, 0, 0, 3'd0, 8'h00, 8'h00);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1 check($sformatf("rst_drop_done%0d", c), 32'(bus.srch_done), 32'd0);
        end
        check_outs("rst_release", 0, 8'h00, 0, 3'd0, 4'd0, 0);

`ifdef CAM_MASK_EN
        // Masked compare: low nibble of the key is don't-care.
        @(negedge clk) drive(1, 0, 0, 0, 3'd1, 8'hF3, 8'h00);
        @(negedge clk) drive(0, 0, 0, 1, 3'd0, 8'h00, 8'hF0);
        bus.srch_mask = 8'h0F;
        @(posedge clk);
        #1 check_outs("mask_0f", 1, 8'h02, 1, 3'd1, 4'd1, 0);
        @(negedge clk) drive(0, 0, 0, 1, 3'd0, 8'h00, 8'hF0);
        bus.srch_mask = 8'h00;
        @(posedge clk);
        #1 check_outs("mask_00", 1, 8'h00, 0, 3'd0, 4'd1, 0);
        @(negedge clk) drive(0, 0, 0, 0, 3'd0, 8'h00, 8'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/param_cam.md
PARAM_CAM -- requirements
Module: param_cam

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the entry and key width in bits.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of entries; legal range 2..256.
REQ-003 Parameter AW, default $clog2(DEPTH), SHALL set the address and index width.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 wr_en  in  1  SHALL be the write strobe.
REQ-007 wr_addr  in  AW  SHALL be the write entry index.
REQ-008 wr_data  in  DATA_W  SHALL be the write data.
REQ-009 inv_en  in  1  SHALL invalidate the entry at wr_addr.
REQ-010 clr_all  in  1  SHALL invalidate all entries.
REQ-011 srch_req  in  1  SHALL be the search strobe.
REQ-012 srch_key  in  DATA_W  SHALL be the search key.
REQ-013 srch_done  out  1  SHALL be a one-cycle result-valid pulse.
REQ-014 match_vec  out  DEPTH  SHALL carry one bit per matching valid entry.
REQ-015 hit  out  1  SHALL be the OR of match_vec.
REQ-016 hit_idx  out  AW  SHALL be the lowest matching index; 0 when there is no hit.
REQ-017 used_cnt  out  AW+1  SHALL be the count of valid entries.
REQ-018 full  out  1  SHALL be high when used_cnt equals DEPTH.

Function
REQ-019 Storage SHALL be DEPTH x DATA_W registers plus a DEPTH-bit valid vector.
REQ-020 When wr_en is high, mem[wr_addr] SHALL be loaded with wr_data and valid[wr_addr] SHALL be set at the next edge.
REQ-021 When inv_en is high, valid[wr_addr] SHALL be cleared and the data SHALL be left unchanged.
REQ-022 Priority SHALL be clr_all > inv_en > wr_en; a lower-priority request in the same cycle SHALL be dropped.
REQ-023 A write or invalidate with wr_addr >= DEPTH SHALL be ignored with no state change.
REQ-024 A search SHALL have a latency of exactly 1 cycle: a request sampled at edge N SHALL drive srch_done, match_vec, hit and hit_idx registered at edge N.
REQ-025 A search SHALL compare against storage and valid state as it stood before edge N; a write in the same cycle SHALL NOT be visible to that search.
REQ-026 Back-to-back searches SHALL be accepted every cycle with no stall.
REQ-027 match_vec, hit and hit_idx SHALL hold their last values while srch_done is low.
REQ-028 used_cnt SHALL be incremented only when a write sets a previously clear valid bit.
REQ-029 used_cnt SHALL be decremented only when an invalidate clears a set valid bit.
REQ-030 A write to a full CAM SHALL overwrite the addressed entry without changing used_cnt.
REQ-031 clr_all SHALL zero used_cnt and the valid vector in one cycle.

Reset
REQ-032 rst high SHALL asynchronously clear the valid vector, used_cnt, full, srch_done, match_vec, hit and hit_idx to 0.
REQ-033 Storage data SHALL NOT be reset.
REQ-034 A search in flight at reset assertion SHALL be discarded, with no srch_done after release.

Configuration
REQ-035 With CAM_MASK_EN defined, an input srch_mask (DATA_W) SHALL be present, and bits set to 1 in it SHALL be don't-care in the comparison.
REQ-036 With CAM_MASK_EN undefined, srch_mask SHALL be absent and the comparison SHALL be an exact binary match.

Structure
REQ-037 Package cam_pkg SHALL hold the default DATA_W and DEPTH constants and the function computing the index width.
REQ-038 Sub-module cam_prio_enc SHALL convert match_vec into hit and hit_idx, lowest index first, combinationally, parametrised by DEPTH.

Verification
REQ-039 Reset, write 0xA5 to entry 3, search 0xA5 -> one cycle later srch_done=1, match_vec=0x08, hit=1, hit_idx=3, used_cnt=1.
REQ-040 Write 0x11 to entries 2 and 6, search 0x11 -> match_vec=0x44, hit_idx=2; then invalidate entry 2 and search again -> match_vec=0x40, hit_idx=6, used_cnt=1.
REQ-041 Same cycle: write 0x7E to entry 0 and search 0x7E -> hit=0; the search in the next cycle -> hit=1, hit_idx=0.
REQ-042 Fill all 8 entries -> full=1, used_cnt=8; then overwrite entry 5 -> used_cnt=8; then clr_all together with wr_en -> used_cnt=0 and search of the written value -> hit=0.
REQ-043 With CAM_MASK_EN defined, entry 1=0xF3, key 0xF0, mask 0x0F -> hit=1, hit_idx=1; with mask 0x00 -> hit=0.
REQ-044 Assert rst in the cycle after srch_req -> srch_done stays 0 and all outputs are 0 after release.
